inv_shift_rows_seq: RTL

//  Sequential AES InvShiftRows unit: the inverse of the forward ShiftRows stage, for the decryption datapath.

---
 rtl/aes_pkg.sv | 19 +
 rtl/isr_row_rotate.sv | 28 ++
 rtl/inv_shift_rows_seq.sv | 96 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES decryption-datapath definitions: state geometry, InvShiftRows FSM encoding, byte indexing.
package aes_pkg;

  localparam int AES_NB  = 4;
  localparam int BYTE_W  = 8;
  localparam int STATE_W = AES_NB * AES_NB * BYTE_W;

  typedef enum logic [1:0] {
    ISR_IDLE = 2'd0,
    ISR_ROT  = 2'd1,
    ISR_HOLD = 2'd2
  } isr_state_t;

  // Column-major byte numbering shared with the forward ShiftRows stage.
  function automatic int idx(input int row, input int col);
    return AES_NB * col + row;
  endfunction

endpackage

// File: rtl/isr_row_rotate.sv
// Combinational row rotator: one-column right rotate of every row above i_step,
// or, with i_full set, the complete InvShiftRows permutation in one pass.
module isr_row_rotate
  import aes_pkg::*;
(
  input  logic [0:STATE_W-1] i_state,
  input  logic [1:0]         i_step,
  input  logic               i_full,
  output logic [0:STATE_W-1] o_state
);

  always_comb begin
    o_state = i_state;
    // Row 0 never moves, so the loop starts at row 1.
    for (int r = 1; r < AES_NB; r++) begin
      for (int c = 0; c < AES_NB; c++) begin
        if (i_full) begin
          o_state[BYTE_W*idx(r, c) +: BYTE_W] =
            i_state[BYTE_W*idx(r, (c - r + AES_NB) % AES_NB) +: BYTE_W];
        end else if (r > int'(i_step)) begin
          o_state[BYTE_W*idx(r, c) +: BYTE_W] =
            i_state[BYTE_W*idx(r, (c + AES_NB - 1) % AES_NB) +: BYTE_W];
        end
      end
    end
  end

endmodule

// File: rtl/inv_shift_rows_seq.sv
// Sequential AES InvShiftRows: IDLE -> ROT (3 column steps) -> HOLD, or IDLE -> HOLD with FAST_PATH.
// Result is held registered in HOLD until out_ready; a new state is accepted only in IDLE.
module inv_shift_rows_seq
  import aes_pkg::*;
#(
  parameter int FAST_PATH = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:STATE_W-1] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:STATE_W-1] out_state,
  output logic               busy
);

  localparam logic LP_FULL = (FAST_PATH != 0);

  isr_state_t         r_state;
  logic [1:0]         r_step;
  logic [0:STATE_W-1] r_work;
  logic [0:STATE_W-1] r_out;
  logic               r_out_vld;
  logic               r_busy;

  logic [0:STATE_W-1] w_rot_in;
  logic [0:STATE_W-1] w_rot;

  // The single rotator sees the raw input in FAST_PATH, the work register otherwise.
  assign w_rot_in = LP_FULL ? in_state : r_work;

  isr_row_rotate u_rot (
    .i_state (w_rot_in),
    .i_step  (r_step),
    .i_full  (LP_FULL),
    .o_state (w_rot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ISR_IDLE;
      r_step    <= 2'd0;
      r_work    <= '0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ISR_IDLE: begin
          if (in_valid) begin
            r_busy <= 1'b1;
            r_step <= 2'd0;
            if (LP_FULL) begin
              r_out     <= w_rot;
              r_out_vld <= 1'b1;
              r_state   <= ISR_HOLD;
            end else begin
              r_work  <= in_state;
              r_state <= ISR_ROT;
            end
          end
        end
        ISR_ROT: begin
          r_work <= w_rot;
          if (r_step == 2'd2) begin
            r_out     <= w_rot;
            r_out_vld <= 1'b1;
            r_state   <= ISR_HOLD;
          end else begin
            r_step <= r_step + 2'd1;
          end
        end
        ISR_HOLD: begin
          if (out_ready) begin
            r_out_vld <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= ISR_IDLE;
          end
        end
        default: begin
          r_out_vld <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ISR_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ISR_IDLE);
  assign out_valid = r_out_vld;
  assign out_state = r_out;
  assign busy      = r_busy;

endmodule
